// File: rtl/phase_measure.sv
// phase_measure: measures the reference period and the ref-to-sig delay in
// clk cycles, averaged over 2^AVG_LOG2 reference periods.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   ref_edge_i  one-cycle strobe, reference falling edge (clk-synchronous)
//   sig_edge_i  one-cycle strobe, measured-signal falling edge
//   start_i     starts a measurement; sampled only in IDLE
//   busy_o      high while arming or measuring
//   period_o    averaged period, clk cycles
//   delay_o     averaged ref-to-sig delay, clk cycles
//   valid_o     one-cycle strobe: period_o/delay_o updated
//   timeout_o   one-cycle strobe: measurement aborted (no ref edge in time)
//   sig_miss_o  sticky for the last measurement: some period had no sig edge
module phase_measure #(
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned AVG_LOG2 = 3,
    parameter int unsigned TIMEOUT  = 2_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ref_edge_i,
    input  logic             sig_edge_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] delay_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             sig_miss_o
);

    localparam int unsigned ACC_W  = CNT_W + AVG_LOG2;
    localparam int unsigned NPER_W = AVG_LOG2 + 1;
    localparam logic [NPER_W-1:0] NPER_LAST = NPER_W'((1 << AVG_LOG2) - 1);
    // Abort when the increment would make cnt reach TIMEOUT.
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEAS,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    pacc_q, pacc_d;
    logic [ACC_W-1:0]    dacc_q, dacc_d;
    logic [NPER_W-1:0]   nper_q, nper_d;
    logic                got_q, got_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic [CNT_W-1:0]    delay_q, delay_d;
    logic                valid_q, valid_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                miss_q, miss_d;
    logic [ACC_W-1:0]    pacc_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pacc_q    <= '0;
            dacc_q    <= '0;
            nper_q    <= '0;
            got_q     <= 1'b0;
            period_q  <= '0;
            delay_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pacc_q    <= pacc_d;
            dacc_q    <= dacc_d;
            nper_q    <= nper_d;
            got_q     <= got_d;
            period_q  <= period_d;
            delay_q   <= delay_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            miss_q    <= miss_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pacc_d    = pacc_q;
        dacc_d    = dacc_q;
        nper_d    = nper_q;
        got_d     = got_q;
        period_d  = period_q;
        delay_d   = delay_q;
        miss_d    = miss_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        pacc_sum  = pacc_q + ACC_W'(cnt_q);

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                    pacc_d  = '0;
                    dacc_d  = '0;
                    nper_d  = '0;
                    miss_d  = 1'b0;
                end
            end

            S_ARM: begin
                if (ref_edge_i) begin
                    state_d = S_MEAS;
                    cnt_d   = CNT_W'(1);
                    got_d   = sig_edge_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_MEAS: begin
                if (ref_edge_i) begin
                    // A sig edge coincident with ref belongs to the new period.
                    pacc_d = pacc_sum;
                    nper_d = nper_q + NPER_W'(1);
                    cnt_d  = CNT_W'(1);
                    got_d  = sig_edge_i;
                    if (!got_q) begin
                        miss_d = 1'b1;
                    end
                    if (nper_q == NPER_LAST) begin
                        state_d  = S_DONE;
                        period_d = CNT_W'(pacc_sum >> AVG_LOG2);
                        delay_d  = CNT_W'(dacc_q >> AVG_LOG2);
                        valid_d  = 1'b1;
                    end
                end else begin
                    if (sig_edge_i && !got_q) begin
                        dacc_d = dacc_q + ACC_W'(cnt_q);
                        got_d  = 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d   = S_IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ARM) || (state_d == S_MEAS);
    end

    assign busy_o     = busy_q;
    assign period_o   = period_q;
    assign delay_o    = delay_q;
    assign valid_o    = valid_q;
    assign timeout_o  = timeout_q;
    assign sig_miss_o = miss_q;

endmodule

// File: doc/phase_measure.md
Name: phase_measure

Overview:
- Consumes single-cycle falling-edge strobes from the phase-detect edge stage: one strobe for the reference channel, one for the measured channel, both already synchronised to clk (200 MHz).
- Measures the reference period and the ref-to-sig delay in clk cycles.
- Averages both over 2^AVG_LOG2 reference periods and hands one registered result, with a valid strobe, to the display/phase-calculation logic.

Parameters:
- CNT_W, 24: width of the cycle counter and of the period_o/delay_o results.
- AVG_LOG2, 3: log2 of the number of reference periods averaged per measurement.
- TIMEOUT, 2_000_000: cycle limit without a reference edge before the measurement is aborted. Must be ≤ 2^CNT_W−1.

Ports:
- clk  in  1  system clock, 200 MHz
- rst_n  in  1  reset, asynchronous, active-low
- ref_edge_i  in  1  one-cycle strobe, reference falling edge
- sig_edge_i  in  1  one-cycle strobe, measured-signal falling edge
- start_i  in  1  starts a measurement; sampled only in IDLE
- busy_o  out  1  high while in ARM or MEAS
- period_o  out  CNT_W  averaged period, clk cycles
- delay_o  out  CNT_W  averaged ref→sig delay, clk cycles
- valid_o  out  1  one-cycle strobe: period_o/delay_o updated
- timeout_o  out  1  one-cycle strobe: measurement aborted
- sig_miss_o  out  1  sticky for the last measurement: at least one period had no sig edge

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all counters and accumulators cleared.
  - period_o=0, delay_o=0, valid_o=0, timeout_o=0, busy_o=0, sig_miss_o=0.
  - Reset mid-measurement discards everything; no valid_o is produced.
- Registers:
  - cnt: CNT_W bits.
  - period_acc, delay_acc: CNT_W+AVG_LOG2 bits each; no overflow is possible.
  - nper: AVG_LOG2+1 bits.
  - got_sig: 1 bit.
- IDLE:
  - On start_i=1, go to ARM. Clear cnt, period_acc, delay_acc, nper and sig_miss_o.
  - start_i is ignored in every other state.
- ARM (wait for the first reference edge):
  - cnt increments every cycle.
  - On ref_edge_i, go to MEAS with cnt←1. Set got_sig←sig_edge_i; a coincident sig edge counts as delay 0.
  - sig_edge_i alone is ignored.
- MEAS (cnt holds cycles elapsed since the last ref edge; cnt=k in the k-th cycle after the edge):
  - sig_edge_i with got_sig=0: delay_acc += cnt, then got_sig←1.
  - Further sig edges in the same period are ignored.
  - ref_edge_i closes the current period:
    - period_acc += cnt; nper += 1.
    - If got_sig=0, then sig_miss_o←1 and the delay contribution is 0.
    - cnt←1, got_sig←sig_edge_i (a simultaneous sig edge belongs to the new period, delay 0).
  - Final period: when the ref edge takes nper to 2^AVG_LOG2, go to DONE on the same clock edge.
    - Load period_o = (period_acc+cnt) >> AVG_LOG2 and delay_o = delay_acc_final >> AVG_LOG2 (truncate).
    - valid_o=1 in the following cycle, i.e. latency 1 cycle after the final ref_edge_i.
- DONE: lasts one cycle (valid_o high), then returns to IDLE. period_o and delay_o hold until the next valid_o.
- Timeout: in ARM or MEAS, if cnt reaches TIMEOUT with no ref_edge_i in that cycle:
  - Pulse timeout_o for 1 cycle and return to IDLE.
  - period_o and delay_o are left unchanged; no valid_o is produced.
- busy_o = (state==ARM || state==MEAS), registered.

Test Plan:
- AVG_LOG2=2. ref_edge every 100 cycles, sig_edge 25 cycles after each ref; pulse start_i → after 5 ref edges: valid_o one cycle, period_o=100, delay_o=25, sig_miss_o=0, busy_o low next cycle.
- Jittered periods 99,101,100,102, delays 10,11,10,12 → period_o=100 (402>>2), delay_o=10 (43>>2).
- sig_edge coincident with every ref_edge → delay_o=0. Extra second sig_edge per period at +50 is ignored → delay_o still 0.
- One period with no sig_edge, others delay 40 (period 100) → delay_o=30 (120>>2), sig_miss_o=1.
- TIMEOUT=1000. start_i with no ref edges → timeout_o pulses exactly 1000 cycles after entering ARM; previous period_o/delay_o retained, no valid_o.
- rst_n low for 1 cycle mid-MEAS → all outputs 0 immediately. A new start yields a clean result (100/25), and start_i asserted while busy has no effect.
